// File: rtl/div_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
interface div_if #(
  parameter int unsigned XLEN = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            is_w;
  logic            is_rem;
  logic            is_unsigned;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;

  modport master (
    output flush, in_valid, is_w, is_rem, is_unsigned, a, b, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  flush, in_valid, is_w, is_rem, is_unsigned, a, b, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow finish at accept.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic clk,
  input  logic resetn,
  div_if.slave io
);
  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            w_q;
  logic            rem_q;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] out_data;

  function automatic logic [XLEN-1:0] ext_half(input logic [HW-1:0] x, input logic sgn);
    return sgn ? {{HW{x[HW-1]}}, x} : {{HW{1'b0}}, x};
  endfunction

  function automatic logic [XLEN-1:0] sext_half(input logic [HW-1:0] x);
    return {{HW{x[HW-1]}}, x};
  endfunction

  // Operand preparation and special-case detection at accept
  logic            sgn_op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic [XLEN-1:0] min_val;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] spec_raw;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    sgn_op   = !io.is_unsigned;
    op_a     = io.is_w ? ext_half(io.a[HW-1:0], sgn_op) : io.a;
    op_b     = io.is_w ? ext_half(io.b[HW-1:0], sgn_op) : io.b;
    a_neg    = sgn_op && op_a[XLEN-1];
    b_neg    = sgn_op && op_b[XLEN-1];
    abs_a    = a_neg ? XLEN'(-op_a) : op_a;
    abs_b    = b_neg ? XLEN'(-op_b) : op_b;
    min_val  = io.is_w ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (op_b == '0);
    ovf      = sgn_op && (op_a == min_val) && (op_b == '1);
    if (div_zero) spec_raw = io.is_rem ? op_a : '1;
    else          spec_raw = io.is_rem ? '0 : op_a;
    spec_res = io.is_w ? sext_half(spec_raw[HW-1:0]) : spec_raw;
  end

  // One restoring step; on the last step the sign-corrected result is formed here too
  logic            msb;
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] res_raw;
  logic [XLEN-1:0] res;
  logic            last;

  always_comb begin
    msb     = w_q ? quo[HW-1] : quo[XLEN-1];
    rem_sh  = {rem, msb};
    ge      = (rem_sh >= {1'b0, dvs});
    rem_nx  = ge ? XLEN'(rem_sh - {1'b0, dvs}) : rem_sh[XLEN-1:0];
    quo_nx  = {quo[XLEN-2:0], ge};
    q_fix   = neg_q ? XLEN'(-quo_nx) : quo_nx;
    r_fix   = neg_r ? XLEN'(-rem_nx) : rem_nx;
    res_raw = rem_q ? r_fix : q_fix;
    res     = w_q ? sext_half(res_raw[HW-1:0]) : res_raw;
    last    = (cnt == (w_q ? CW'(HW - 1) : CW'(XLEN - 1)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      w_q       <= 1'b0;
      rem_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (io.flush) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            w_q      <= io.is_w;
            rem_q    <= io.is_rem;
            in_ready <= 1'b0;
            if (div_zero || ovf) begin
              out_data  <= spec_res;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              quo   <= abs_a;
              dvs   <= abs_b;
              rem   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              cnt   <= '0;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            out_data  <= res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.out_data  = out_data;
endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized checks of div_unit against an arithmetic reference model.
module tb_div_unit;
  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  div_if #(.XLEN(XLEN)) dif ();
  div_unit #(.XLEN(XLEN)) dut (.clk(clk), .resetn(resetn), .io(dif));

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [63:0] ra, rb, rexp;
  bit          rw, rr, ru, rspec, seen;
  int          lat, sel, exp_lat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division with the ISA's corner-case rules
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input bit w, input bit rem, input bit uns,
                                          output bit special);
    logic [63:0] ua, ub, q, r, res;
    longint      sa, sb, min_v;
    special = 1'b0;
    if (w) begin
      ua    = {32'h0, a[31:0]};
      ub    = {32'h0, b[31:0]};
      sa    = longint'($signed(a[31:0]));
      sb    = longint'($signed(b[31:0]));
      min_v = -64'sd2147483648;
    end else begin
      ua    = a;
      ub    = b;
      sa    = $signed(a);
      sb    = $signed(b);
      min_v = 64'sh8000_0000_0000_0000;
    end
    if (uns) begin
      if (ub == 0) begin
        q = '1; r = ua; special = 1'b1;
      end else begin
        q = ua / ub; r = ua % ub;
      end
    end else begin
      if (sb == 0) begin
        q = '1; r = 64'(sa); special = 1'b1;
      end else if (sa == min_v && sb == -1) begin
        q = 64'(sa); r = '0; special = 1'b1;
      end else begin
        q = 64'(sa / sb); r = 64'(sa % sb);
      end
    end
    res = rem ? r : q;
    if (w) res = {{32{res[31]}}, res[31:0]};
    return res;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input bit w, input bit rem, input bit uns);
    int n;
    n = 0;
    while (!dif.in_ready && n < 100) begin
      step();
      n++;
    end
    check("in_ready before issue", 64'(dif.in_ready), 64'd1);
    dif.a = a; dif.b = b; dif.is_w = w; dif.is_rem = rem; dif.is_unsigned = uns;
    dif.in_valid = 1'b1;
    step();
    dif.in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen
  task automatic wait_valid(output int l);
    l = 1;
    while (!dif.out_valid && l < 100) begin
      step();
      l++;
    end
  endtask

  task automatic handshake();
    dif.out_ready = 1'b1;
    step();
    dif.out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input bit w, input bit rem, input bit uns,
                          input logic [63:0] exp, input int e_lat);
    int l;
    issue(a, b, w, rem, uns);
    wait_valid(l);
    check({tag, " data"}, dif.out_data, exp);
    check({tag, " latency"}, 64'(l), 64'(e_lat));
    handshake();
  endtask

  initial begin
    dif.flush = 1'b0; dif.in_valid = 1'b0; dif.out_ready = 1'b0;
    dif.is_w = 1'b0; dif.is_rem = 1'b0; dif.is_unsigned = 1'b0;
    dif.a = '0; dif.b = '0;
    #12;
    check("reset in_ready", 64'(dif.in_ready), 64'd1);
    check("reset out_valid", 64'(dif.out_valid), 64'd0);
    check("reset out_data", dif.out_data, 64'd0);
    resetn = 1'b1;
    step();

    directed("DIV -7/2",   -64'sd7, 64'd2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    directed("REM -7/2",   -64'sd7, 64'd2, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    directed("DIVU /0",    64'h1234, 64'd0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    directed("REMU /0",    64'h1234, 64'd0, 0, 1, 1, 64'h1234, 1);
    directed("DIV ovf",    64'h8000_0000_0000_0000, '1, 0, 0, 0, 64'h8000_0000_0000_0000, 1);
    directed("REM ovf",    64'h8000_0000_0000_0000, '1, 0, 1, 0, 64'h0, 1);
    directed("DIVUW",      64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 1, 0, 1, 64'h0000_0000_7FFF_FFFF, 33);
    directed("DIVW ovf",   64'h1_8000_0000, '1, 1, 0, 0, 64'hFFFF_FFFF_8000_0000, 1);

    // Result held while consumer stalls
    issue(64'h1234, 64'd0, 0, 0, 1);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      check("hold out_valid", 64'(dif.out_valid), 64'd1);
      check("hold out_data", dif.out_data, 64'hFFFF_FFFF_FFFF_FFFF);
      check("hold in_ready", 64'(dif.in_ready), 64'd0);
      step();
    end
    dif.out_ready = 1'b1;
    step();
    dif.out_ready = 1'b0;
    check("post handshake in_ready", 64'(dif.in_ready), 64'd1);
    check("post handshake out_valid", 64'(dif.out_valid), 64'd0);

    // Flush while busy
    issue(-64'sd7, 64'd2, 0, 0, 0);
    repeat (10) step();
    dif.flush = 1'b1;
    step();
    dif.flush = 1'b0;
    check("flush busy in_ready", 64'(dif.in_ready), 64'd1);
    check("flush busy out_valid", 64'(dif.out_valid), 64'd0);
    seen = 1'b0;
    repeat (80) begin
      seen |= dif.out_valid;
      step();
    end
    check("flush no result", 64'(seen), 64'd0);

    // Async reset mid-op
    issue(-64'sd7, 64'd2, 0, 0, 0);
    repeat (10) step();
    #2;
    resetn = 1'b0;
    #1;
    check("async reset out_valid", 64'(dif.out_valid), 64'd0);
    check("async reset out_data", dif.out_data, 64'd0);
    check("async reset in_ready", 64'(dif.in_ready), 64'd1);
    step();
    resetn = 1'b1;
    step();

    // Flush wins over a simultaneous request
    dif.a = 64'h55; dif.b = 64'd0; dif.is_w = 1'b0; dif.is_rem = 1'b0; dif.is_unsigned = 1'b1;
    dif.flush = 1'b1;
    dif.in_valid = 1'b1;
    step();
    dif.flush = 1'b0;
    dif.in_valid = 1'b0;
    check("flush+valid in_ready", 64'(dif.in_ready), 64'd1);
    check("flush+valid out_valid", 64'(dif.out_valid), 64'd0);
    step();
    check("flush+valid no result", 64'(dif.out_valid), 64'd0);

    // Randomized operations with random stalls and flushes
    for (int n = 0; n < 600; n++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rw = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      ru = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      if (sel == 0) begin
        rb = '0;
      end else if (sel == 1) begin
        rb = '1;
        ra = rw ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
      end else if (sel < 8) begin
        rb = 64'($urandom_range(1, 15));
        if ($urandom_range(0, 1) == 1) rb = -rb;
      end
      rexp = ref_div(ra, rb, rw, rr, ru, rspec);
      exp_lat = rspec ? 1 : (rw ? 33 : 65);
      issue(ra, rb, rw, rr, ru);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, 20)) step();
        dif.flush = 1'b1;
        step();
        dif.flush = 1'b0;
        check("rnd flush state", 64'({dif.in_ready, dif.out_valid}), 64'd2);
      end else begin
        wait_valid(lat);
        check("rnd data", dif.out_data, rexp);
        check("rnd latency", 64'(lat), 64'(exp_lat));
        repeat ($urandom_range(0, 3)) step();
        check("rnd held data", dif.out_data, rexp);
        handshake();
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
